// File: rtl/signed_calc_solver_if.sv
// Request/result bundle for signed_calc_solver: start + target in, busy/done and
// the first matching (A,B) pair with a saturating match count out.
interface signed_calc_solver_if;
    logic              i_start;
    logic signed [8:0] i_target;
    logic              o_busy;
    logic              o_done;
    logic              o_found;
    logic signed [4:0] o_au;
    logic signed [4:0] o_bu;
    logic        [1:0] o_count;

    modport master (
        output i_start, i_target,
        input  o_busy, o_done, o_found, o_au, o_bu, o_count
    );

    modport slave (
        input  i_start, i_target,
        output o_busy, o_done, o_found, o_au, o_bu, o_count
    );
endinterface

// File: rtl/signed_calc_solver.sv
// Brute-force inverter of F = 6*A - 11*B over A,B in 0..MAX_VAL, one candidate per cycle.
// Define SOLVER_EARLY_EXIT_EN to stop the scan right after the first match.
module signed_calc_solver #(
    parameter int MAX_VAL = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    signed_calc_solver_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    localparam logic [3:0] MAX4 = 4'(MAX_VAL);

    state_t            state_q, state_d;
    logic        [3:0] a_q, a_d;
    logic        [3:0] b_q, b_d;
    logic signed [8:0] target_q, target_d;
    logic              found_q, found_d;
    logic signed [4:0] au_q, au_d;
    logic signed [4:0] bu_q, bu_d;
    logic        [1:0] count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic signed [9:0] prod;
    logic signed [9:0] target_ext;
    logic              hit;
    logic              last_cand;

    // Widened to 10 bits so -11*15 = -165 and 6*15 = 90 both fit without wrap.
    assign prod       = 10'sd6 * $signed({6'd0, a_q}) - 10'sd11 * $signed({6'd0, b_q});
    assign target_ext = {target_q[8], target_q};
    assign hit        = (prod == target_ext);
    assign last_cand  = (a_q == MAX4) && (b_q == MAX4);

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path leaves one unassigned (no latches).
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        target_d = target_q;
        found_d  = found_q;
        au_d     = au_q;
        bu_d     = bu_q;
        count_d  = count_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d  = SEARCH;
                    target_d = bus.i_target;
                    found_d  = 1'b0;
                    au_d     = '0;
                    bu_d     = '0;
                    count_d  = '0;
                    a_d      = '0;
                    b_d      = '0;
                end
            end

            SEARCH: begin
                if (hit) begin
                    if (!found_q) begin
                        found_d = 1'b1;
                        au_d    = {1'b0, a_q};
                        bu_d    = {1'b0, b_q};
                        count_d = 2'd1;
                    end else if (count_q != 2'd3) begin
                        count_d = count_q + 2'd1;
                    end
                end

                if (b_q == MAX4) begin
                    b_d = '0;
                    a_d = a_q + 4'd1;
                end else begin
                    b_d = b_q + 4'd1;
                end

`ifdef SOLVER_EARLY_EXIT_EN
                if (last_cand || hit) state_d = DONE;
`else
                if (last_cand) state_d = DONE;
`endif
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so they align with state_q.
        busy_d = (state_d == SEARCH);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            target_q <= '0;
            found_q  <= 1'b0;
            au_q     <= '0;
            bu_q     <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            target_q <= target_d;
            found_q  <= found_d;
            au_q     <= au_d;
            bu_q     <= bu_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;
    assign bus.o_found = found_q;
    assign bus.o_au    = au_q;
    assign bus.o_bu    = bu_q;
    assign bus.o_count = count_q;

endmodule

// File: tb/tb_signed_calc_solver.sv
// Directed-vector bench for signed_calc_solver (MAX_VAL=15); honours SOLVER_EARLY_EXIT_EN.
module tb_signed_calc_solver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors    = 0;
    int   miscompares = 0;

    signed_calc_solver_if bus();

    signed_calc_solver #(.MAX_VAL(15)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        bus.i_start  = 1'b0;
        bus.i_target = '0;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.o_busy, bus.o_done, bus.o_found, bus.o_au, bus.o_bu, bus.o_count} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b found=%b au=%0d bu=%0d count=%0d, want all 0",
                     bus.o_busy, bus.o_done, bus.o_found, bus.o_au, bus.o_bu, bus.o_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Accept edge is counted as edge 1, so a full scan shows o_done at edge 257.
    task automatic test_solve(input string name, input logic signed [8:0] t,
                              input bit ef, input int eau, input int ebu, input int ecnt_full);
        int edges, busy_cyc, guard, exp_edges, exp_busy, exp_cnt;
        logic              f;
        logic signed [4:0] au, bu;
        logic        [1:0] cnt;
`ifdef SOLVER_EARLY_EXIT_EN
        exp_edges = ef ? (eau * 16 + ebu + 2) : 257;
        exp_cnt   = ef ? 1 : 0;
`else
        exp_edges = 257;
        exp_cnt   = ecnt_full;
`endif
        exp_busy = exp_edges - 1;

        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_target = t;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus.i_start  = 1'b0;
        bus.i_target = 9'sd170;   // must not disturb the latched target
        busy_cyc = 0;
        guard    = 0;
        while (!bus.o_done && guard < 400) begin
            if (bus.o_busy) busy_cyc++;
            @(posedge clk);
            edges++;
            @(negedge clk);
            guard++;
        end

        vectors++;
        if (bus.o_done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_timeout: o_done not seen within 400 cycles", name);
        end
        vectors++;
        if (edges !== exp_edges) begin
            miscompares++;
            $display("FAIL %s_latency: o_done at edge %0d, want %0d", name, edges, exp_edges);
        end
        vectors++;
        if (busy_cyc !== exp_busy) begin
            miscompares++;
            $display("FAIL %s_busy: busy for %0d cycles, want %0d", name, busy_cyc, exp_busy);
        end
        vectors++;
        if (bus.o_found !== ef || bus.o_au !== 5'(eau) || bus.o_bu !== 5'(ebu) || bus.o_count !== 2'(exp_cnt)) begin
            miscompares++;
            $display("FAIL %s_result: got found=%b au=%0d bu=%0d count=%0d, want found=%b au=%0d bu=%0d count=%0d",
                     name, bus.o_found, bus.o_au, bus.o_bu, bus.o_count, ef, eau, ebu, exp_cnt);
        end
        f = bus.o_found; au = bus.o_au; bu = bus.o_bu; cnt = bus.o_count;

        repeat (3) @(negedge clk);
        vectors++;
        if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_found !== ef ||
            bus.o_au !== 5'(eau) || bus.o_bu !== 5'(ebu) || bus.o_count !== 2'(exp_cnt)) begin
            miscompares++;
            $display("FAIL %s_hold: got done=%b busy=%b found=%b au=%0d bu=%0d count=%0d, want done=0 busy=0 found=%b au=%0d bu=%0d count=%0d",
                     name, bus.o_done, bus.o_busy, bus.o_found, bus.o_au, bus.o_bu, bus.o_count,
                     f, au, bu, cnt);
        end
    endtask

    task automatic test_reset_mid_search();
        int done_cnt;
        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_target = 9'sd0;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (40) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.o_busy, bus.o_done, bus.o_found, bus.o_au, bus.o_bu, bus.o_count} !== 15'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got busy=%b done=%b found=%b au=%0d bu=%0d count=%0d, want all 0",
                     bus.o_busy, bus.o_done, bus.o_found, bus.o_au, bus.o_bu, bus.o_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.o_done) done_cnt++;
        end
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("FAIL midreset_no_done: saw %0d o_done cycles, want 0", done_cnt);
        end
        test_solve("after_reset_t1", 9'sd1, 1'b1, 2, 1, 2);
    endtask

    task automatic test_start_during_search();
        int done_pulses;
        logic signed [4:0] au_at_done, bu_at_done;
        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_target = 9'sd90;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (10) @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_target = 9'sd0;
        repeat (3) @(negedge clk);
        bus.i_start = 1'b0;
        done_pulses = 0;
        au_at_done  = '0;
        bu_at_done  = '0;
        repeat (400) begin
            @(negedge clk);
            if (bus.o_done) begin
                done_pulses++;
                au_at_done = bus.o_au;
                bu_at_done = bus.o_bu;
            end
        end
        vectors++;
        if (done_pulses !== 1) begin
            miscompares++;
            $display("FAIL restart_pulses: saw %0d o_done pulses, want 1", done_pulses);
        end
        vectors++;
        if (au_at_done !== 5'sd15 || bu_at_done !== 5'sd0) begin
            miscompares++;
            $display("FAIL restart_result: got au=%0d bu=%0d, want au=15 bu=0", au_at_done, bu_at_done);
        end
        test_solve("post_restart_m165", -9'sd165, 1'b1, 0, 15, 1);
    endtask

    initial begin
        test_reset();
        test_solve("t0",    9'sd0,    1'b1, 0,  0,  2);
        test_solve("t90",   9'sd90,   1'b1, 15, 0,  1);
        test_solve("tm165", -9'sd165, 1'b1, 0,  15, 1);
        test_solve("t1",    9'sd1,    1'b1, 2,  1,  2);
        test_solve("tm5",   -9'sd5,   1'b1, 1,  1,  2);
        test_solve("t12",   9'sd12,   1'b1, 2,  0,  2);
        test_solve("t100",  9'sd100,  1'b0, 0,  0,  0);
        test_reset_mid_search();
        test_start_during_search();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
